// File: rtl/rt_get_responder_pkg.sv
// Shared types and defaults for the rt_get responder.
// Holds the head-tracking state enum, the default latency window and the
// saturating age type used by the age FIFO and the top.
package rt_get_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_MIN_LAT = 2;
  localparam int DEF_MAX_LAT = 5;
  localparam int AW          = 3;

  typedef logic [AW-1:0] age_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AGING  = 2'd1,
    WINDOW = 2'd2
  } rt_state_e;

  // One aging step: count up by one, never past max_age.
  function automatic age_t sat_inc(input age_t a, input age_t max_age);
    return (a >= max_age) ? max_age : a + age_t'(1);
  endfunction

endpackage

// File: rtl/rt_get_responder_if.sv
// Handshake bundle between the requesting bench (master) and the
// rt_get responder (slave): get/ack inputs plus response and status outputs.
interface rt_get_responder_if #(
  parameter int DEPTH = 4
);

  logic                     get;
  logic                     controllable_ack;
  logic                     response;
  logic [$clog2(DEPTH):0]   pending;
  logic                     busy;
  logic                     error;

  modport master (
    output get,
    output controllable_ack,
    input  response,
    input  pending,
    input  busy,
    input  error
  );

  modport slave (
    input  get,
    input  controllable_ack,
    output response,
    output pending,
    output busy,
    output error
  );

endinterface

// File: rtl/rt_get_responder_age_fifo.sv
// Circular buffer of saturating age counters, one per outstanding request.
// Every resident entry ages by one per clock; a push writes a fresh age of 0
// at the tail, a pop retires the head. Pointers wrap modulo DEPTH.
module rt_age_fifo
  import rt_get_pkg::*;
#(
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int MAX_LAT = DEF_MAX_LAT,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  output age_t        head_age,
  output age_t        second_age,
  output logic [PW:0] count,
  output logic        full,
  output logic        empty,
  output logic        any_nonhead_at_max
);

  localparam age_t MAX_AGE = age_t'(MAX_LAT);

  age_t          ages [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head_age   = ages[rd_ptr];
  assign second_age = ages[rd_ptr + PW'(1)];
  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);

  // Flag any waiting entry behind the head that has already hit the deadline.
  always_comb begin
    any_nonhead_at_max = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if ((i < int'(count)) && (ages[rd_ptr + PW'(i)] == MAX_AGE)) begin
        any_nonhead_at_max = 1'b1;
      end
    end
  end

  // Age all slots, then apply push at the tail and pop at the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ages[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ages[i] <= sat_inc(ages[i], MAX_AGE);
      end
      if (push) begin
        ages[wr_ptr] <= '0;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rt_get_responder.sv
// Far end of the get/response real-time handshake. Queues get pulses with
// per-request ages and answers each one with a single response pulse once its
// age lies in [MIN_LAT, MAX_LAT]; the exact cycle is picked by
// controllable_ack, or forced when the head reaches MAX_LAT. error is sticky
// on queue overflow or deadline miss.
// Optional macro RT_RESP_TRACE_EN adds simulation-only trace messages.
module rt_get_responder
  import rt_get_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MIN_LAT = DEF_MIN_LAT,
  parameter int MAX_LAT = DEF_MAX_LAT
) (
  input  logic              clk,
  input  logic              rst,
  rt_get_responder_if.slave bus
);

  localparam int   PW      = $clog2(DEPTH);
  localparam age_t MIN_AGE = age_t'(MIN_LAT);
  localparam age_t MAX_AGE = age_t'(MAX_LAT);

  rt_state_e   state;
  rt_state_e   state_next;
  age_t        head_age;
  age_t        second_age;
  age_t        aged_head;
  age_t        new_head_age;
  logic [PW:0] count;
  logic        full;
  logic        empty;
  logic        nonhead_late;
  logic        serve;
  logic        push;
  logic        overflow;
  logic        nonempty_next;
  logic        response_q;
  logic        error_q;

  rt_age_fifo #(
    .DEPTH   (DEPTH),
    .MAX_LAT (MAX_LAT)
  ) u_fifo (
    .clk                (clk),
    .rst                (rst),
    .push               (push),
    .pop                (serve),
    .head_age           (head_age),
    .second_age         (second_age),
    .count              (count),
    .full               (full),
    .empty              (empty),
    .any_nonhead_at_max (nonhead_late)
  );

  // Serve decision and head-tracking next state; WINDOW means the head is
  // old enough to be answered at the coming edge.
  always_comb begin
    aged_head     = sat_inc(head_age, MAX_AGE);
    serve         = (state == WINDOW) && (bus.controllable_ack || (aged_head == MAX_AGE));
    push          = bus.get && (!full || serve);
    overflow      = bus.get && full && !serve;
    new_head_age  = '0;
    nonempty_next = 1'b0;
    state_next    = IDLE;
    if (serve) begin
      if (count > (PW+1)'(1)) begin
        new_head_age = sat_inc(second_age, MAX_AGE);
      end
      nonempty_next = (count > (PW+1)'(1)) || push;
    end else begin
      if (!empty) begin
        new_head_age = aged_head;
      end
      nonempty_next = !empty || push;
    end
    if (nonempty_next) begin
      state_next = (sat_inc(new_head_age, MAX_AGE) >= MIN_AGE) ? WINDOW : AGING;
    end
  end

  // State, one-cycle response pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      response_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_next;
      response_q <= serve;
      error_q    <= error_q | overflow | nonhead_late;
    end
  end

  assign bus.response = response_q;
  assign bus.pending  = count;
  assign bus.busy     = (count != '0);
  assign bus.error    = error_q;

`ifdef RT_RESP_TRACE_EN
  // Trace pushes, responses and the first cause of the sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) $display("get");
      if (serve) $display("response, age=%0d", aged_head);
      if (overflow && !error_q) $display("overflow");
      if (nonhead_late && !error_q) $display("deadline");
    end
  end
`else
  // No trace output in the default build.
`endif

endmodule

// File: tb/tb_rt_get_responder.sv
// Self-checking bench for rt_get_responder: a fixed vector table for reset,
// minimum and forced latency, hand-written sequences for burst, overflow and
// full-queue push/pop with mid-queue reset, then random traffic against a
// queue-of-push-times reference model.
module tb_rt_get_responder;

  localparam int DEPTH   = 4;
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 5;

  logic clk;
  logic rst;

  rt_get_responder_if #(.DEPTH(DEPTH)) bus ();

  rt_get_responder #(
    .DEPTH   (DEPTH),
    .MIN_LAT (MIN_LAT),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic get;
    logic ack;
    logic exp_resp;
    int   exp_pend;
    logic exp_err;
  } vec_t;

  vec_t vecs [13];

  int num_checks = 0;
  int num_pass   = 0;

  // Reference model: each queued request is remembered by its push edge.
  int edge_no = 0;
  int model_q [$];
  bit m_resp  = 1'b0;
  bit m_err   = 1'b0;

  task automatic model_edge(input logic r, input logic g, input logic a);
    bit served;
    int age;
    edge_no++;
    if (r) begin
      model_q.delete();
      m_resp = 1'b0;
      m_err  = 1'b0;
    end else begin
      served = 1'b0;
      if (model_q.size() > 0) begin
        age = edge_no - model_q[0];
        if (age >= MIN_LAT && (a || age >= MAX_LAT)) served = 1'b1;
      end
      for (int i = 1; i < model_q.size(); i++) begin
        if (edge_no - model_q[i] > MAX_LAT) m_err = 1'b1;
      end
      if (served) void'(model_q.pop_front());
      if (g) begin
        if (model_q.size() < DEPTH) model_q.push_back(edge_no);
        else m_err = 1'b1;
      end
      m_resp = served;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    num_checks++;
    if (actual == expected) num_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and
  // leave the bench #1 after the edge for sampling.
  task automatic applyStimulus(input logic r, input logic g, input logic a);
    rst                  = r;
    bus.get              = g;
    bus.controllable_ack = a;
    @(posedge clk);
    model_edge(r, g, a);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".response"}, int'(bus.response), int'(m_resp));
    checkOutput({tag, ".pending"},  int'(bus.pending),  model_q.size());
    checkOutput({tag, ".busy"},     int'(bus.busy),     int'(model_q.size() != 0));
    checkOutput({tag, ".error"},    int'(bus.error),    int'(m_err));
  endtask

  int resp_count;
  int first_resp;
  int last_resp;
  int peak_dut;
  int peak_model;

  initial begin
    rst                  = 1'b1;
    bus.get              = 1'b0;
    bus.controllable_ack = 1'b0;

    // Reset with get held, then minimum latency, then forced latency.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].get, vecs[v].ack);
      checkOutput($sformatf("vec%0d.response", v), int'(bus.response), int'(vecs[v].exp_resp));
      checkOutput($sformatf("vec%0d.pending", v),  int'(bus.pending),  vecs[v].exp_pend);
      checkOutput($sformatf("vec%0d.busy", v),     int'(bus.busy),     int'(vecs[v].exp_pend != 0));
      checkOutput($sformatf("vec%0d.error", v),    int'(bus.error),    int'(vecs[v].exp_err));
    end

    // Burst of four gets with ack held: four back-to-back responses.
    applyStimulus(1'b1, 1'b0, 1'b0);
    resp_count = 0; first_resp = -1; last_resp = -1; peak_dut = 0; peak_model = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, c < 4, 1'b1);
      checkModel("burst");
      if (bus.response) begin
        resp_count++;
        if (first_resp < 0) first_resp = c;
        last_resp = c;
      end
      if (int'(bus.pending) > peak_dut) peak_dut = int'(bus.pending);
      if (model_q.size() > peak_model) peak_model = model_q.size();
    end
    checkOutput("burst.responses", resp_count, 4);
    checkOutput("burst.consecutive", last_resp - first_resp, 3);
    checkOutput("burst.peak_pending", peak_dut, peak_model);
    checkOutput("burst.error", int'(bus.error), 0);

    // Five gets with no ack: fifth dropped, error set, four responses.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkModel("ovf.fill");
    end
    checkOutput("ovf.pending_full", int'(bus.pending), DEPTH);
    checkOutput("ovf.error_set", int'(bus.error), 1);
    resp_count = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkModel("ovf.drain");
      if (bus.response) resp_count++;
    end
    checkOutput("ovf.responses", resp_count, 4);
    checkOutput("ovf.error_sticky", int'(bus.error), 1);

    // Full queue: serve and push on the same edge, then reset mid-queue.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("full.pending", int'(bus.pending), 4);
    checkOutput("full.response", int'(bus.response), 1);
    checkOutput("full.error", int'(bus.error), 0);
    checkModel("full");
    applyStimulus(1'b1, 1'b0, 1'b1);
    resp_count = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkModel("rst_mid");
      if (bus.response) resp_count++;
    end
    checkOutput("rst_mid.responses", resp_count, 0);

    // Random traffic with occasional resets against the reference model.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0);
      checkModel("rand");
    end

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
